// File: rtl/pulse_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_seq_pkg
// Purpose  : Shared definitions for the pulse_seq sequencer. Holds the FSM
//            state encoding and the layout of a packed pulse descriptor.
//            Descriptor layout for a field width of W bits:
//              [0]          default level
//              [W:1]        trailing gap (cycles)
//              [2W:W+1]     pulse width (cycles)
//            Total descriptor width is 2*W+1 bits.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FIRE      = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_e;

  localparam int unsigned DESC_LEVEL_OFS = 0;
  localparam int unsigned DESC_GAP_OFS   = 1;

  // Bit offset of the pulse-width field for a given field width.
  function automatic int unsigned desc_width_ofs(input int unsigned ram_width);
    return ram_width + 1;
  endfunction

  // Total packed descriptor width for a given field width.
  function automatic int unsigned desc_total_width(input int unsigned ram_width);
    return 2 * ram_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pulse_seq_fifo
// Purpose  : Synchronous descriptor FIFO for pulse_seq. Registered full,
//            empty and occupancy flags. A push while full is accepted only
//            when a pop happens in the same cycle. flush_i empties the FIFO
//            and overrides push/pop.
// Ports    : clk_i    - clock
//            rst_ni   - asynchronous active-low reset
//            flush_i  - discard all entries
//            push_i   - write wdata_i (dropped when full and not popping)
//            wdata_i  - descriptor to write
//            pop_i    - remove head entry (ignored when empty)
//            rdata_o  - current head entry
//            full_o   - DEPTH entries held
//            empty_o  - no entries held
//            count_o  - occupancy
// Revision : 1.0 - initial release
// ============================================================================
module pulse_seq_fifo
  import pulse_seq_pkg::*;
#(
  parameter int unsigned WIDTH = desc_total_width(32),
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i & ~empty_q;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_q | pop_ok);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pulse_seq.sv
`default_nettype none
// ============================================================================
// Module   : pulse_seq
// Purpose  : Programmable pulse-train sequencer in front of sigpulse.
//            Descriptors {width, gap, level} are queued in a FIFO; on start
//            each one fires a sigpulse strobe, waits for the completion
//            strobe, then idles for the programmed gap before the next.
// Config   : `define PULSE_SEQ_TIMEOUT_EN adds the TIMEOUT_MARGIN parameter,
//            a completion watchdog and the sticky timeout_err output.
// Ports    : io_clk / io_rst_n     - clock, async active-low reset
//            wr_en/wr_width/wr_gap/wr_level - descriptor push
//            start / abort         - playback control strobes
//            fifo_full/empty/count - FIFO status
//            wr_ovf                - sticky dropped-write flag
//            busy / seq_done       - sequencer status
//            sp_en, sp_pulseWidth, sp_defaultLevel, sp_dis - to sigpulse
//            sp_pulse_valid        - sigpulse completion strobe
//            timeout_err           - sticky watchdog flag (option only)
// Revision : 1.0 - initial release
// ============================================================================
module pulse_seq
  import pulse_seq_pkg::*;
#(
  parameter int unsigned _RAM_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
`ifdef PULSE_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_MARGIN = 16
`endif
) (
  input  logic                    io_clk,
  input  logic                    io_rst_n,
  input  logic                    wr_en,
  input  logic [_RAM_WIDTH-1:0]   wr_width,
  input  logic [_RAM_WIDTH-1:0]   wr_gap,
  input  logic                    wr_level,
  input  logic                    start,
  input  logic                    abort,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    wr_ovf,
  output logic                    busy,
  output logic                    seq_done,
  output logic                    sp_en,
  output logic [_RAM_WIDTH-1:0]   sp_pulseWidth,
  output logic                    sp_defaultLevel,
  output logic                    sp_dis,
`ifdef PULSE_SEQ_TIMEOUT_EN
  output logic                    timeout_err,
`endif
  input  logic                    sp_pulse_valid
);

  localparam int unsigned RW      = _RAM_WIDTH;
  localparam int unsigned DW      = desc_total_width(RW);
  localparam int unsigned WID_OFS = desc_width_ofs(RW);
  localparam logic [RW-1:0] G_ONE = RW'(1);

  // ---------------------------------------------------------------- FIFO
  logic          push, pop, flush;
  logic [DW-1:0] fifo_wdata, fifo_rdata;
  logic [RW-1:0] head_width, head_gap;
  logic          head_level;

  assign push       = wr_en & ~abort;
  assign fifo_wdata = {wr_width, wr_gap, wr_level};
  assign head_width = fifo_rdata[WID_OFS +: RW];
  assign head_gap   = fifo_rdata[DESC_GAP_OFS +: RW];
  assign head_level = fifo_rdata[DESC_LEVEL_OFS];

  pulse_seq_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (io_clk),
    .rst_ni  (io_rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------- FSM
  state_e        state_q, state_d;
  logic          sp_en_q, sp_en_d;
  logic          sp_dis_q, sp_dis_d;
  logic          seq_done_q, seq_done_d;
  logic          busy_q;
  logic          wr_ovf_q, wr_ovf_d;
  logic [RW-1:0] width_q, width_d;
  logic          level_q, level_d;
  logic [RW-1:0] gap_q, gap_d;
  logic [RW-1:0] gcnt_q, gcnt_d;
  logic          advance;

`ifdef PULSE_SEQ_TIMEOUT_EN
  localparam logic [RW:0] WD_ONE   = (RW + 1)'(1);
  localparam logic [RW:0] MARGIN_C = (RW + 1)'(TIMEOUT_MARGIN);
  logic [RW:0] wd_q, wd_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  // A write is only an overflow if it was not absorbed by a same-cycle pop.
  assign wr_ovf_d = wr_ovf_q | (wr_en & ~abort & fifo_full & ~pop);

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    flush      = 1'b0;
    sp_en_d    = 1'b0;
    sp_dis_d   = 1'b0;
    seq_done_d = 1'b0;
    width_d    = width_q;
    level_d    = level_q;
    gap_d      = gap_q;
    gcnt_d     = gcnt_q;
    advance    = 1'b0;
`ifdef PULSE_SEQ_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
`endif

    if (abort) begin
      state_d  = S_IDLE;
      flush    = 1'b1;
      sp_dis_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: advance = start;

        S_FIRE: begin
`ifdef PULSE_SEQ_TIMEOUT_EN
          if (wd_q != '0) wd_d = wd_q - WD_ONE;
`endif
          if (width_q != '0) begin
            state_d = S_WAIT_DONE;
          end else if (gap_q != '0) begin
            state_d = S_GAP;
            gcnt_d  = gap_q;
          end else begin
            advance = 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (sp_pulse_valid) begin
            if (gap_q != '0) begin
              state_d = S_GAP;
              gcnt_d  = gap_q;
            end else begin
              advance = 1'b1;
            end
          end
`ifdef PULSE_SEQ_TIMEOUT_EN
          else if (wd_q <= WD_ONE) begin
            state_d       = S_IDLE;
            flush         = 1'b1;
            sp_dis_d      = 1'b1;
            timeout_err_d = 1'b1;
          end else begin
            wd_d = wd_q - WD_ONE;
          end
`endif
        end

        // Counter is loaded with a non-zero gap, so it stops at 1.
        S_GAP: begin
          if (gcnt_q <= G_ONE) advance = 1'b1;
          else                 gcnt_d  = gcnt_q - G_ONE;
        end

        default: state_d = S_IDLE;
      endcase

      // End of a step: the head is popped and latched while entering FIRE,
      // so sp_en and its qualifiers appear together in the FIRE cycle.
      if (advance) begin
        if (!fifo_empty) begin
          state_d = S_FIRE;
          pop     = 1'b1;
          width_d = head_width;
          level_d = head_level;
          gap_d   = head_gap;
          sp_en_d = (head_width != '0);
`ifdef PULSE_SEQ_TIMEOUT_EN
          wd_d    = {1'b0, head_width} + MARGIN_C;
`endif
        end else begin
          state_d    = S_IDLE;
          seq_done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q    <= S_IDLE;
      sp_en_q    <= 1'b0;
      sp_dis_q   <= 1'b0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_ovf_q   <= 1'b0;
      width_q    <= '0;
      level_q    <= 1'b0;
      gap_q      <= '0;
      gcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      sp_en_q    <= sp_en_d;
      sp_dis_q   <= sp_dis_d;
      seq_done_q <= seq_done_d;
      busy_q     <= (state_d != S_IDLE);
      wr_ovf_q   <= wr_ovf_d;
      width_q    <= width_d;
      level_q    <= level_d;
      gap_q      <= gap_d;
      gcnt_q     <= gcnt_d;
    end
  end

`ifdef PULSE_SEQ_TIMEOUT_EN
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

  assign wr_ovf          = wr_ovf_q;
  assign busy            = busy_q;
  assign seq_done        = seq_done_q;
  assign sp_en           = sp_en_q;
  assign sp_pulseWidth   = width_q;
  assign sp_defaultLevel = level_q;
  assign sp_dis          = sp_dis_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_seq
// Purpose  : Self-checking bench for pulse_seq (DEPTH=8, 32-bit fields).
//            Includes a sigpulse stand-in that returns the completion
//            strobe a programmable number of cycles after each sp_en.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_seq;

  logic        io_clk = 1'b0;
  logic        io_rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_width = '0;
  logic [31:0] wr_gap = '0;
  logic        wr_level = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sp_pulse_valid = 1'b0;
  logic        fifo_full, fifo_empty, wr_ovf, busy, seq_done;
  logic [3:0]  fifo_count;
  logic        sp_en, sp_defaultLevel, sp_dis;
  logic [31:0] sp_pulseWidth;
`ifdef PULSE_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  pulse_seq #(._RAM_WIDTH(32), .DEPTH(8)) dut (
    .io_clk          (io_clk),
    .io_rst_n        (io_rst_n),
    .wr_en           (wr_en),
    .wr_width        (wr_width),
    .wr_gap          (wr_gap),
    .wr_level        (wr_level),
    .start           (start),
    .abort           (abort),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .fifo_count      (fifo_count),
    .wr_ovf          (wr_ovf),
    .busy            (busy),
    .seq_done        (seq_done),
    .sp_en           (sp_en),
    .sp_pulseWidth   (sp_pulseWidth),
    .sp_defaultLevel (sp_defaultLevel),
    .sp_dis          (sp_dis),
`ifdef PULSE_SEQ_TIMEOUT_EN
    .timeout_err     (timeout_err),
`endif
    .sp_pulse_valid  (sp_pulse_valid)
  );

  always #5 io_clk = ~io_clk;

  int unsigned cyc = 0;
  always @(posedge io_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned w;
    int unsigned g;
    logic        l;
  } desc_t;

  typedef struct {
    logic        we;
    logic        st;
    logic        ab;
    int unsigned w;
    int unsigned cnt;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        busy;
    logic        done;
  } vec_t;

  desc_t       plan[$];
  int unsigned en_cyc[$];
  int unsigned en_w[$];
  logic        en_l[$];
  int unsigned done_cyc[$];
  int unsigned dis_cyc[$];

  bit          resp_on    = 1'b1;
  int unsigned resp_fixed = 0;   // 0: respond after sp_pulseWidth cycles
  int unsigned resp_cnt   = 0;

  // Event recorder and sigpulse stand-in, both on the falling edge.
  initial forever begin
    @(negedge io_clk);
    if (sp_en) begin
      en_cyc.push_back(cyc);
      en_w.push_back(sp_pulseWidth);
      en_l.push_back(sp_defaultLevel);
    end
    if (seq_done) done_cyc.push_back(cyc);
    if (sp_dis)   dis_cyc.push_back(cyc);
    sp_pulse_valid = 1'b0;
    if (!io_rst_n) begin
      resp_cnt = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) sp_pulse_valid = 1'b1;
      end
      if (sp_en && resp_on) resp_cnt = (resp_fixed != 0) ? resp_fixed : sp_pulseWidth;
    end
  end

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    io_rst_n = 1'b0;
    wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
    tick();
    io_rst_n = 1'b1;
    tick();
  endtask

  task automatic push_plan();
    foreach (plan[i]) begin
      wr_en    = 1'b1;
      wr_width = plan[i].w;
      wr_gap   = plan[i].g;
      wr_level = plan[i].l;
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Start playback of whatever is queued (described by plan) and compare the
  // observed sp_en / seq_done timeline against one derived from the rules:
  // first fire one cycle after start; a fired pulse completes d cycles later
  // and the next fire follows completion by gap+1; a zero-width entry is a
  // one-cycle FIRE plus gap cycles.
  task automatic play_plan(input string tag);
    int unsigned k, t, deadline;
    int unsigned exp_c[$];
    int unsigned exp_w[$];
    logic        exp_l[$];
    en_cyc.delete(); en_w.delete(); en_l.delete(); done_cyc.delete();
    k = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = k + 1;
    foreach (plan[i]) begin
      if (plan[i].w != 0) begin
        exp_c.push_back(t);
        exp_w.push_back(plan[i].w);
        exp_l.push_back(plan[i].l);
        t = t + ((resp_fixed != 0) ? resp_fixed : plan[i].w) + plan[i].g + 1;
      end else begin
        t = t + plan[i].g + 1;
      end
    end
    deadline = t + 10;
    while (done_cyc.size() == 0 && cyc < deadline) tick();
    check({tag, " en_count"}, en_cyc.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < en_cyc.size(); i++) begin
      check($sformatf("%s en%0d_cycle", tag, i), en_cyc[i], exp_c[i]);
      check($sformatf("%s en%0d_width", tag, i), en_w[i], exp_w[i]);
      check($sformatf("%s en%0d_level", tag, i), en_l[i], exp_l[i]);
    end
    check({tag, " seq_done_seen"}, done_cyc.size() != 0, 1);
    if (done_cyc.size() != 0) check({tag, " seq_done_cycle"}, done_cyc[0], t);
    tick();
    check({tag, " seq_done_once"}, done_cyc.size(), 1);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " empty_after"}, fifo_empty, 1);
    if (plan.size() != 0) begin
      check({tag, " width_held"}, sp_pulseWidth, plan[plan.size()-1].w);
      check({tag, " level_held"}, sp_defaultLevel, plan[plan.size()-1].l);
    end
  endtask

  function automatic vec_t mk(logic we, logic st, logic ab, int unsigned w, int unsigned cnt,
                              logic full, logic empty, logic ovf, logic bsy, logic done);
    vec_t v;
    v.we = we; v.st = st; v.ab = ab; v.w = w; v.cnt = cnt;
    v.full = full; v.empty = empty; v.ovf = ovf; v.busy = bsy; v.done = done;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int unsigned k, f, guard;
    desc_t q[$];
    desc_t d;
    bit we;
    bit ovf_m;

    // FIFO fill / overflow / pop-while-full / abort / empty-start vectors.
    for (int i = 1; i <= 9; i++)
      tbl[i-1] = mk(1, 0, 0, 100 + i, (i > 8) ? 8 : i, i >= 8, 0, i >= 9, 0, 0);
    tbl[9]  = mk(1, 1, 0, 110, 8, 1, 0, 1, 1, 0);  // start + push while full
    tbl[10] = mk(1, 0, 0, 111, 8, 1, 0, 1, 1, 0);  // push while full, no pop
    tbl[11] = mk(1, 0, 1, 112, 0, 0, 1, 1, 0, 0);  // abort discards push
    tbl[12] = mk(0, 1, 0, 0,   0, 0, 1, 1, 0, 1);  // start while empty
    tbl[13] = mk(0, 0, 0, 0,   0, 0, 1, 1, 0, 0);

    // Reset state
    do_reset();
    check("rst fifo_empty", fifo_empty, 1);
    check("rst fifo_full", fifo_full, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst wr_ovf", wr_ovf, 0);
    check("rst busy", busy, 0);
    check("rst seq_done", seq_done, 0);
    check("rst sp_en", sp_en, 0);
    check("rst sp_pulseWidth", sp_pulseWidth, 0);
    check("rst sp_defaultLevel", sp_defaultLevel, 0);
    check("rst sp_dis", sp_dis, 0);

    // Table-driven vectors
    resp_on = 1'b0;
    for (int i = 0; i < 14; i++) begin
      wr_en = tbl[i].we; start = tbl[i].st; abort = tbl[i].ab;
      wr_width = tbl[i].w; wr_gap = 1; wr_level = 1'b0;
      tick();
      check($sformatf("vec%0d count", i), fifo_count, tbl[i].cnt);
      check($sformatf("vec%0d full", i), fifo_full, tbl[i].full);
      check($sformatf("vec%0d empty", i), fifo_empty, tbl[i].empty);
      check($sformatf("vec%0d wr_ovf", i), wr_ovf, tbl[i].ovf);
      check($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      check($sformatf("vec%0d seq_done", i), seq_done, tbl[i].done);
    end
    wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    resp_on = 1'b1;

    // Two-pulse train: widths 1000/200, gaps 5/0
    do_reset();
    plan.delete();
    d.w = 1000; d.g = 5; d.l = 1'b0; plan.push_back(d);
    d.w = 200;  d.g = 0; d.l = 1'b1; plan.push_back(d);
    push_plan();
    play_plan("train");

    // Zero-width entry: no strobe, FIRE + 3 gap cycles, then next FIRE
    plan.delete();
    d.w = 0;  d.g = 3; d.l = 1'b0; plan.push_back(d);
    d.w = 50; d.g = 0; d.l = 1'b0; plan.push_back(d);
    push_plan();
    play_plan("zero_w");

    // Abort in WAIT_DONE with three entries still queued
    do_reset();
    resp_on = 1'b0;
    plan.delete();
    for (int i = 0; i < 4; i++) begin
      d.w = 30; d.g = 2; d.l = 1'b1; plan.push_back(d);
    end
    push_plan();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("abort pre busy", busy, 1);
    check("abort pre count", fifo_count, 3);
    done_cyc.delete();
    abort = 1'b1; wr_en = 1'b1; wr_width = 7;
    tick();
    abort = 1'b0; wr_en = 1'b0;
    check("abort sp_dis", sp_dis, 1);
    check("abort fifo_empty", fifo_empty, 1);
    check("abort busy", busy, 0);
    check("abort seq_done", seq_done, 0);
    tick();
    check("abort sp_dis pulse", sp_dis, 0);
    check("abort push dropped", fifo_count, 0);
    check("abort no seq_done", done_cyc.size(), 0);
    start = 1'b1; tick(); start = 1'b0;
    check("abort start seq_done", seq_done, 1);
    check("abort start busy", busy, 0);
    tick();
    check("abort seq_done pulse", seq_done, 0);
    resp_on = 1'b1;

    // Asynchronous reset in the middle of GAP
    do_reset();
    plan.delete();
    d.w = 20; d.g = 10; d.l = 1'b1; plan.push_back(d);
    d.w = 5;  d.g = 0;  d.l = 1'b0; plan.push_back(d);
    push_plan();
    k = cyc;
    start = 1'b1; tick(); start = 1'b0;
    f = k + 1;
    guard = 0;
    while (cyc < f + 24 && guard < 100) begin tick(); guard++; end
    check("arst pre busy", busy, 1);
    check("arst pre level", sp_defaultLevel, 1);
    check("arst pre count", fifo_count, 1);
    #2;
    io_rst_n = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst fifo_empty", fifo_empty, 1);
    check("arst fifo_count", fifo_count, 0);
    check("arst sp_pulseWidth", sp_pulseWidth, 0);
    check("arst sp_defaultLevel", sp_defaultLevel, 0);
    check("arst sp_en", sp_en, 0);
    check("arst seq_done", seq_done, 0);
    tick();
    io_rst_n = 1'b1;
    tick();

`ifdef PULSE_SEQ_TIMEOUT_EN
    // Watchdog: width 10 + margin 16, completion never returned
    do_reset();
    resp_on = 1'b0;
    plan.delete();
    d.w = 10; d.g = 0; d.l = 1'b0; plan.push_back(d);
    push_plan();
    k = cyc;
    start = 1'b1; tick(); start = 1'b0;
    f = k + 1;
    guard = 0;
    while (cyc < f + 25 && guard < 100) begin tick(); guard++; end
    check("tmo early", timeout_err, 0);
    check("tmo early busy", busy, 1);
    tick();
    check("tmo err", timeout_err, 1);
    check("tmo sp_dis", sp_dis, 1);
    check("tmo busy", busy, 0);
    check("tmo empty", fifo_empty, 1);
    tick();
    check("tmo sticky", timeout_err, 1);
    resp_on = 1'b1;
`endif

    // Randomized fills checked against a queue model, then timeline playback
    do_reset();
    ovf_m = 1'b0;
    for (int it = 0; it < 6; it++) begin
      q.delete();
      for (int c = 0; c < 12; c++) begin
        we = ($urandom_range(0, 9) < 7);
        d.w = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
        d.g = $urandom_range(0, 4);
        d.l = 1'($urandom_range(0, 1));
        wr_en = we; wr_width = d.w; wr_gap = d.g; wr_level = d.l;
        tick();
        if (we) begin
          if (q.size() < 8) q.push_back(d);
          else              ovf_m = 1'b1;
        end
        check($sformatf("rnd%0d count", it), fifo_count, q.size());
        check($sformatf("rnd%0d full", it), fifo_full, q.size() == 8);
        check($sformatf("rnd%0d empty", it), fifo_empty, q.size() == 0);
        check($sformatf("rnd%0d wr_ovf", it), wr_ovf, ovf_m);
      end
      wr_en = 1'b0;
      plan = q;
      play_plan($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
